// File: rtl/ode_pkg.sv
// Shared definitions for the ODE accelerator datapath stages.
// Holds default word/address widths, the update-unit state encoding and
// the saturating adder used both here and in the step-control adder path.
package ode_pkg;

  // Signed fixed-point word width.
  localparam int DATA_W = 16;
  // Fractional bits; the multiplier already rescales its products to this format.
  localparam int FRAC_W = 8;
  // Shared memory address width.
  localparam int ADDR_W = 16;

  // Update-unit FSM encoding.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_F    = 3'd1;
  localparam logic [2:0] S_MUL_START = 3'd2;
  localparam logic [2:0] S_MUL_WAIT  = 3'd3;
  localparam logic [2:0] S_READ_X    = 3'd4;
  localparam logic [2:0] S_ADD_WRITE = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  // Result of a saturating add: clipped word plus a flag set when clipping happened.
  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] sum;
  } sat_res_t;

  // Two's-complement add at DATA_W+1 bits, clipped to the DATA_W signed range.
  // The extra top bit disagrees with the DATA_W sign bit exactly when the
  // true sum does not fit; the extra bit then gives the direction of the clip.
  function automatic sat_res_t sat_add(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
    logic [DATA_W:0] wide;
    sat_res_t        res;
    wide    = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    res.ovf = (wide[DATA_W] != wide[DATA_W-1]);
    if (!res.ovf) begin
      res.sum = wide[DATA_W-1:0];
    end else if (wide[DATA_W]) begin
      res.sum = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res.sum = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/euler_update_unit_if.sv
// Bundle of the update unit's control, memory and multiplier signals.
// The slave modport is the update unit's view; the master modport is the
// surrounding controller/memory/multiplier side.
interface euler_update_unit_if;
  import ode_pkg::*;

  // Pass control and parameters.
  logic              start;
  logic [ADDR_W-1:0] n;
  logic [DATA_W-1:0] step;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] f_base;
  logic [ADDR_W-1:0] out_base;

  // Shared memory port (read data returns one cycle after the read strobe).
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Shared multiplier start/done handshake.
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_result;

  // Status.
  logic              busy;
  logic              done;
  logic              overflow;

  modport slave (
    input  start, n, step, x_base, f_base, out_base,
    input  mem_rdata, mul_done, mul_result,
    output mem_addr, mem_read, mem_write, mem_wdata,
    output mul_start, mul_a, mul_b,
    output busy, done, overflow
  );

  modport master (
    output start, n, step, x_base, f_base, out_base,
    output mem_rdata, mul_done, mul_result,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    input  mul_start, mul_a, mul_b,
    input  busy, done, overflow
  );

endinterface

// File: rtl/sat_adder.sv
// Combinational DATA_W signed add with saturation to the word range.
// Latency: zero cycles (pure combinational).
// No handshake; the result follows the operands within the same cycle.
module sat_adder
  import ode_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf
);

  sat_res_t w_res;

  // Evaluate the shared saturating add so this path and step control clip identically.
  always_comb begin
    w_res = sat_add(i_a, i_b);
  end

  assign o_sum = w_res.sum;
  assign o_ovf = w_res.ovf;

endmodule

// File: rtl/euler_update_unit.sv
// Explicit-Euler state update: X_out[i] = sat(X[i] + h*F[i]) for i = 0..n-1.
// Latency: n*(5+L)+1 cycles from start to done, L = multiplier latency.
// Stalls in MUL_WAIT until mul_done; start is ignored while busy.
module euler_update_unit
  import ode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  euler_update_unit_if.slave bus
);

  // FSM state and per-pass latched parameters.
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_h;
  logic [ADDR_W-1:0] r_x_ptr;
  logic [ADDR_W-1:0] r_f_ptr;
  logic [ADDR_W-1:0] r_out_ptr;

  // Per-element datapath registers.
  logic [DATA_W-1:0] r_f;
  logic [DATA_W-1:0] r_p;
  logic              r_ovf;

  // Adder result for the element currently in ADD_WRITE.
  logic [DATA_W-1:0] w_sum;
  logic              w_clip;

  // Combinational output drives before they reach the bus.
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_mul_start;
  logic [DATA_W-1:0] w_mul_a;
  logic [DATA_W-1:0] w_mul_b;
  logic              w_busy;
  logic              w_done;
  logic              w_overflow;

  // X[i] arrives on mem_rdata during ADD_WRITE; p_reg holds h*F[i].
  sat_adder u_sat_adder (
    .i_a   (bus.mem_rdata),
    .i_b   (r_p),
    .o_sum (w_sum),
    .o_ovf (w_clip)
  );

  // Sequence one element at a time: fetch F, multiply by h, fetch X, add and store.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_h       <= '0;
      r_x_ptr   <= '0;
      r_f_ptr   <= '0;
      r_out_ptr <= '0;
      r_f       <= '0;
      r_p       <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A new pass re-latches everything; without start the state holds.
          if (bus.start) begin
            r_cnt     <= bus.n;
            r_h       <= bus.step;
            r_x_ptr   <= bus.x_base;
            r_f_ptr   <= bus.f_base;
            r_out_ptr <= bus.out_base;
            r_ovf     <= 1'b0;
            r_state   <= (bus.n == '0) ? S_DONE : S_READ_F;
          end
        end
        S_READ_F: begin
          r_state <= S_MUL_START;
        end
        S_MUL_START: begin
          // Keep F so the multiplier operands stay stable after mem_rdata moves on.
          r_f     <= bus.mem_rdata;
          r_state <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (bus.mul_done) begin
            r_p     <= bus.mul_result;
            r_state <= S_READ_X;
          end
        end
        S_READ_X: begin
          r_state <= S_ADD_WRITE;
        end
        S_ADD_WRITE: begin
          if (w_clip) begin
            r_ovf <= 1'b1;
          end
          if (r_cnt == ADDR_W'(1)) begin
            r_state <= S_DONE;
          end else begin
            // Pointers wrap naturally at 2^ADDR_W.
            r_cnt     <= r_cnt - ADDR_W'(1);
            r_x_ptr   <= r_x_ptr + ADDR_W'(1);
            r_f_ptr   <= r_f_ptr + ADDR_W'(1);
            r_out_ptr <= r_out_ptr + ADDR_W'(1);
            r_state   <= S_READ_F;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Decode outputs from state; everything is forced low while reset is asserted
  // so an interrupted pass can never emit a write or multiplier start.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_wdata = '0;
    w_mul_start = 1'b0;
    w_mul_a     = '0;
    w_mul_b     = '0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_overflow  = 1'b0;
    if (!rst) begin
      w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
      w_done     = (r_state == S_DONE);
      w_overflow = r_ovf;
      case (r_state)
        S_READ_F: begin
          w_mem_read = 1'b1;
          w_mem_addr = r_f_ptr;
        end
        S_MUL_START: begin
          // F is taken straight from the read port to save a cycle.
          w_mul_start = 1'b1;
          w_mul_a     = bus.mem_rdata;
          w_mul_b     = r_h;
        end
        S_MUL_WAIT: begin
          w_mul_a = r_f;
          w_mul_b = r_h;
        end
        S_READ_X: begin
          w_mem_read = 1'b1;
          w_mem_addr = r_x_ptr;
        end
        S_ADD_WRITE: begin
          w_mem_write = 1'b1;
          w_mem_addr  = r_out_ptr;
          w_mem_wdata = w_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mul_start = w_mul_start;
  assign bus.mul_a     = w_mul_a;
  assign bus.mul_b     = w_mul_b;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.overflow  = w_overflow;

endmodule

// File: tb/tb_euler_update_unit.sv
// Directed bench for euler_update_unit with a behavioural memory and a
// multiplier whose done pulse rises mul_lat cycles after it accepts start.
module tb_euler_update_unit;

  logic clk;
  logic rst;

  euler_update_unit_if bus();

  euler_update_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory contents are only preloaded by the stimulus; DUT writes are logged.
  logic [15:0] mem [0:65535];

  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Multiplier: accepts start at an edge, raises done for one cycle mul_lat
  // cycles later with the product rescaled by 8 fractional bits.
  int          mul_lat = 1;
  int          mul_cnt = 0;
  logic signed [31:0] mul_full;
  assign mul_full = $signed(bus.mul_a) * $signed(bus.mul_b);

  always @(posedge clk) begin
    if (rst) begin
      mul_cnt      <= 0;
      bus.mul_done <= 1'b0;
    end else if (bus.mul_start) begin
      mul_cnt        <= mul_lat;
      bus.mul_done   <= 1'b0;
      bus.mul_result <= mul_full[23:8];
    end else if (mul_cnt == 1) begin
      mul_cnt      <= 0;
      bus.mul_done <= 1'b1;
    end else begin
      bus.mul_done <= 1'b0;
      if (mul_cnt > 1) mul_cnt <= mul_cnt - 1;
    end
  end

  // Per-pass activity log.
  logic [15:0] rd_q[$];
  logic [15:0] wr_a_q[$];
  logic [15:0] wr_d_q[$];
  int          n_mul;
  int          stab_err;
  logic        in_wait;
  logic [15:0] wa, wb;
  logic        ovf_c1;
  int          cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    v = 'x;
    if (idx < rd_q.size()) v = rd_q[idx];
    chk($sformatf("%s_rd%0d", tag, idx), {48'd0, v}, {48'd0, exp});
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] ea, input logic [15:0] ed);
    logic [15:0] va, vd;
    va = 'x;
    vd = 'x;
    if (idx < wr_a_q.size()) begin
      va = wr_a_q[idx];
      vd = wr_d_q[idx];
    end
    chk($sformatf("%s_wa%0d", tag, idx), {48'd0, va}, {48'd0, ea});
    chk($sformatf("%s_wd%0d", tag, idx), {48'd0, vd}, {48'd0, ed});
  endtask

  // Start a pass, log activity each cycle until done or budget; optionally
  // pulse a conflicting start (n=7, bases 0x5000) at cycle 'inject'.
  task automatic run_pass(input logic [15:0] n, input logic [15:0] h,
                          input logic [15:0] xb, input logic [15:0] fb,
                          input logic [15:0] ob, input int budget,
                          input int inject, output int cycles);
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    n_mul    = 0;
    stab_err = 0;
    in_wait  = 1'b0;
    @(negedge clk);
    bus.n        = n;
    bus.step     = h;
    bus.x_base   = xb;
    bus.f_base   = fb;
    bus.out_base = ob;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles    = 1;
    ovf_c1    = bus.overflow;
    while (cycles < budget && bus.done !== 1'b1) begin
      if (bus.mem_read) rd_q.push_back(bus.mem_addr);
      if (bus.mem_write) begin
        wr_a_q.push_back(bus.mem_addr);
        wr_d_q.push_back(bus.mem_wdata);
      end
      if (in_wait) begin
        if (bus.mul_a !== wa || bus.mul_b !== wb) stab_err++;
        if (bus.mul_done) in_wait = 1'b0;
      end
      if (bus.mul_start) begin
        n_mul++;
        in_wait = 1'b1;
        wa      = bus.mul_a;
        wb      = bus.mul_b;
      end
      if (cycles == inject) begin
        bus.start    = 1'b1;
        bus.n        = 16'd7;
        bus.x_base   = 16'h5000;
        bus.f_base   = 16'h5000;
        bus.out_base = 16'h5000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
  endtask

  int k;
  int wr_seen;
  int busy_seen;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.n        = '0;
    bus.step     = '0;
    bus.x_base   = '0;
    bus.f_base   = '0;
    bus.out_base = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_status", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    chk("rst_strobes", {61'd0, bus.mem_read, bus.mem_write, bus.mul_start}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_status", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    chk("idle_buses", {bus.mem_addr, bus.mem_wdata, bus.mul_a, bus.mul_b}, 64'd0);

    // Basic element: 0x0100 + 0.5*0x0200 = 0x0200, L=1.
    mul_lat      = 1;
    mem[16'h0100] = 16'h0200;
    mem[16'h0010] = 16'h0100;
    run_pass(16'd1, 16'h0080, 16'h0010, 16'h0100, 16'h0200, 40, -1, cyc);
    chk("t1_done", {63'd0, bus.done}, 64'd1);
    chk("t1_cycles", cyc, 7);
    chk("t1_nwr", wr_a_q.size(), 1);
    chk_wr("t1", 0, 16'h0200, 16'h0200);
    chk_rd("t1", 0, 16'h0100);
    chk_rd("t1", 1, 16'h0010);
    chk("t1_ovf", {63'd0, bus.overflow}, 64'd0);
    chk("t1_busy", {63'd0, bus.busy}, 64'd0);

    // Vector, L=3, with a conflicting start injected mid-pass.
    mul_lat = 3;
    for (int i = 0; i < 4; i++) begin
      mem[16'h1000 + i] = 16'((i + 1) * 256);
      mem[16'h2000 + i] = 16'h0000;
    end
    run_pass(16'd4, 16'h0100, 16'h2000, 16'h1000, 16'h2100, 80, 3, cyc);
    chk("t2_done", {63'd0, bus.done}, 64'd1);
    chk("t2_cycles", cyc, 33);
    chk("t2_nwr", wr_a_q.size(), 4);
    chk("t2_nrd", rd_q.size(), 8);
    chk("t2_nmul", n_mul, 4);
    chk("t2_stable", stab_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk_wr("t2", i, 16'h2100 + 16'(i), 16'((i + 1) * 256));
      chk_rd("t2", 2 * i, 16'h1000 + 16'(i));
      chk_rd("t2", 2 * i + 1, 16'h2000 + 16'(i));
    end

    // Positive saturation.
    mul_lat       = 2;
    mem[16'h1100] = 16'h0200;
    mem[16'h1200] = 16'h7F00;
    run_pass(16'd1, 16'h0100, 16'h1200, 16'h1100, 16'h1300, 40, -1, cyc);
    chk("t3a_cycles", cyc, 8);
    chk_wr("t3a", 0, 16'h1300, 16'h7FFF);
    chk("t3a_ovf", {63'd0, bus.overflow}, 64'd1);

    // Negative saturation.
    mem[16'h1101] = 16'hFE00;
    mem[16'h1201] = 16'h8100;
    run_pass(16'd1, 16'h0100, 16'h1201, 16'h1101, 16'h1301, 40, -1, cyc);
    chk_wr("t3b", 0, 16'h1301, 16'h8000);
    chk("t3b_ovf", {63'd0, bus.overflow}, 64'd1);

    // Zero-length pass from DONE: done next cycle, no activity, overflow cleared.
    run_pass(16'd0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 10, -1, cyc);
    chk("t4_cycles", cyc, 1);
    chk("t4_done", {63'd0, bus.done}, 64'd1);
    chk("t4_strobes", {62'd0, bus.mem_read, bus.mul_start}, 64'd0);
    chk("t4_ovf", {63'd0, bus.overflow}, 64'd0);

    // Re-arm from DONE: in-place N=2, h=0.25.
    mul_lat       = 1;
    mem[16'h3100] = 16'h0100;
    mem[16'h3101] = 16'hFF00;
    mem[16'h3000] = 16'h0010;
    mem[16'h3001] = 16'h0020;
    run_pass(16'd2, 16'h0040, 16'h3000, 16'h3100, 16'h3000, 60, -1, cyc);
    chk("t5_cycles", cyc, 13);
    chk_wr("t5", 0, 16'h3000, 16'h0050);
    chk_wr("t5", 1, 16'h3001, 16'hFFE0);
    chk("t5_ovf", {63'd0, bus.overflow}, 64'd0);

    // Address wrap on the X pointer.
    mem[16'h4000] = 16'h0100;
    mem[16'h4001] = 16'h0100;
    mem[16'hFFFF] = 16'h0001;
    mem[16'h0000] = 16'h0002;
    run_pass(16'd2, 16'h0100, 16'hFFFF, 16'h4000, 16'h4100, 60, -1, cyc);
    chk("t6_cycles", cyc, 13);
    chk_rd("t6", 0, 16'h4000);
    chk_rd("t6", 1, 16'hFFFF);
    chk_rd("t6", 2, 16'h4001);
    chk_rd("t6", 3, 16'h0000);
    chk_wr("t6", 0, 16'h4100, 16'h0101);
    chk_wr("t6", 1, 16'h4101, 16'h0102);

    // Reset while waiting on the multiplier.
    mul_lat       = 5;
    mem[16'h4200] = 16'h0300;
    mem[16'h4300] = 16'h0001;
    @(negedge clk);
    bus.n        = 16'd1;
    bus.step     = 16'h0100;
    bus.x_base   = 16'h4300;
    bus.f_base   = 16'h4200;
    bus.out_base = 16'h4400;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (bus.mul_start !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t7_mulstart", {63'd0, bus.mul_start}, 64'd1);
    @(posedge clk); #1;
    chk("t7_wait", {bus.mul_a, bus.mul_b, 31'd0, bus.busy}, {16'h0300, 16'h0100, 32'd1});
    rst = 1'b1;
    #1;
    chk("t7_rst_status", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    chk("t7_rst_strobes", {61'd0, bus.mem_read, bus.mem_write, bus.mul_start}, 64'd0);
    chk("t7_rst_buses", {bus.mem_addr, bus.mem_wdata, bus.mul_a, bus.mul_b}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t7_idle_status", {61'd0, bus.busy, bus.done, bus.overflow}, 64'd0);
    chk("t7_idle_buses", {bus.mem_addr, bus.mem_wdata, bus.mul_a, bus.mul_b}, 64'd0);
    wr_seen   = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.mem_write) wr_seen++;
      if (bus.busy || bus.done) busy_seen++;
    end
    chk("t7_no_write", wr_seen, 0);
    chk("t7_stays_idle", busy_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
